// File: rtl/if_pc_gen_pkg.sv
// Shared IF-stage constants: bus widths, chip-enable levels and the reset fetch address.
`timescale 1ns/1ps
package if_pc_gen_pkg;

  localparam int unsigned InstAddrW  = 32;
  localparam int unsigned StallW     = 6;

  localparam logic [InstAddrW-1:0] ZeroWord   = '0;
  localparam logic [InstAddrW-1:0] DefResetPc = 32'h0000_0000;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;

endpackage

// File: rtl/if_pc_gen.sv
// IF-stage fetch-address generator: sequential +4 stepping, flush/branch redirect,
// and a one-deep buffer for a branch resolved while IF is stalled.
`timescale 1ns/1ps
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter int unsigned     ADDR_W   = InstAddrW,
  parameter int unsigned     STALL_W  = StallW,
  parameter logic [ADDR_W-1:0] RESET_PC = DefResetPc
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce
);

  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;

  logic [ADDR_W-1:0] new_pc_al;
  logic [ADDR_W-1:0] branch_target_al;
  logic              unused_stall;

  assign new_pc_al        = {new_pc[ADDR_W-1:2], 2'b00};
  assign branch_target_al = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign unused_stall     = ^stall;

  // The pc update is gated by the registered ce, so the edge that enables
  // the ROM leaves pc at RESET_PC for one full fetch cycle.
  always_comb begin
    ce_d          = ChipEnable;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (ce_q == ChipEnable) begin
      if (flush) begin
        pc_d         = new_pc_al;
        pend_valid_d = 1'b0;
      end else if (stall[0] == Stop) begin
        if (branch_flag_i) begin
          pend_target_d = branch_target_al;
          pend_valid_d  = 1'b1;
        end
      end else if (branch_flag_i) begin
        pc_d         = branch_target_al;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_d = pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q          <= ChipDisable;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      ce_q          <= ce_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc = pc_q;
  assign ce = ce_q;

endmodule
